// File: rtl/seq_group_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit that resolves one GROUP_BITS-wide group per clock
// using nibble lookahead. It also exports word-level generate/propagate for chaining.
module seq_group_adder #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned GROUP_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             gg,
    output logic             pg
);

    localparam int unsigned NGROUPS = (WIDTH + GROUP_BITS - 1) / GROUP_BITS;
    localparam int unsigned PW      = NGROUPS * GROUP_BITS;
    localparam int unsigned NNIB    = GROUP_BITS / 4;
    localparam int unsigned KW      = $clog2(NGROUPS + 1);
    localparam int unsigned TOPBIT  = (WIDTH - 1) % GROUP_BITS;
    localparam logic [KW-1:0] KLast = KW'(NGROUPS - 1);
    localparam logic [KW-1:0] KDone = KW'(NGROUPS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Carry into every bit of a group: nibble-level lookahead, ripple inside each nibble.
    function automatic logic [GROUP_BITS:0] group_carries(input logic [GROUP_BITS-1:0] ga,
                                                          input logic [GROUP_BITS-1:0] gb,
                                                          input logic ci);
        logic [GROUP_BITS:0] c;
        logic [NNIB:0]       nc;
        logic [3:0]          bg, bp;
        logic                ng, np;
        c     = '0;
        nc    = '0;
        nc[0] = ci;
        for (int j = 0; j < int'(NNIB); j++) begin
            bg = ga[4*j +: 4] & gb[4*j +: 4];
            bp = ga[4*j +: 4] | gb[4*j +: 4];
            ng = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1]) |
                 (bp[3] & bp[2] & bp[1] & bg[0]);
            np = &bp;
            nc[j+1]  = ng | (np & nc[j]);
            c[4*j]   = nc[j];
            for (int i = 1; i < 4; i++) begin
                c[4*j+i] = bg[i-1] | (bp[i-1] & c[4*j+i-1]);
            end
        end
        c[GROUP_BITS] = nc[NNIB];
        return c;
    endfunction

    function automatic logic carry_at(input logic [GROUP_BITS-1:0] ga,
                                      input logic [GROUP_BITS-1:0] gb,
                                      input logic ci, input int unsigned pos);
        logic [GROUP_BITS:0] c;
        c = group_carries(ga, gb, ci);
        return c[pos];
    endfunction

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [PW-1:0]       a_q, b_q, work_q;
    logic                carry_q, gcarry_q, pg_acc_q;
    logic                out_valid_q, cout_q, ovf_q, zero_q, gg_q, pg_q;
    logic [WIDTH-1:0]    sum_q;

    int                  gbase;
    logic                is_top;
    logic [GROUP_BITS-1:0] ga, gb, gpad, gsum;
    logic [GROUP_BITS:0] cv;
    logic                carry_nx, gcarry_nx, gprop;

    always_comb begin
        gbase  = int'(k_q) * int'(GROUP_BITS);
        is_top = (k_q == KLast);
        ga     = a_q[gbase +: GROUP_BITS];
        gb     = b_q[gbase +: GROUP_BITS];
        for (int i = 0; i < int'(GROUP_BITS); i++) begin
            gpad[i] = (gbase + i >= int'(WIDTH));
        end
        cv   = group_carries(ga, gb, carry_q);
        // Padding bits are forced to 0 so zero can fold in the whole work register.
        gsum = (ga ^ gb ^ cv[GROUP_BITS-1:0]) & ~gpad;
        // On the top group, the carry of interest is out of bit WIDTH-1, not the padding.
        carry_nx  = is_top ? cv[TOPBIT+1] : cv[GROUP_BITS];
        gcarry_nx = carry_at(ga, gb, gcarry_q, is_top ? TOPBIT + 1 : GROUP_BITS);
        gprop     = &(ga | gb | gpad);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (k_q == KDone) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            gcarry_q    <= 1'b0;
            pg_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            gg_q        <= 1'b0;
            pg_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= PW'(a);
                        b_q      <= PW'(op_sub ? ~b : b);
                        carry_q  <= op_sub | cin;
                        gcarry_q <= 1'b0;
                        k_q      <= '0;
                        pg_acc_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (k_q == KDone) begin
                        sum_q       <= work_q[WIDTH-1:0];
                        cout_q      <= carry_q;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                                       (work_q[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q      <= ~|work_q;
                        gg_q        <= gcarry_q;
                        pg_q        <= pg_acc_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        work_q[gbase +: GROUP_BITS] <= gsum;
                        carry_q  <= carry_nx;
                        gcarry_q <= gcarry_nx;
                        pg_acc_q <= pg_acc_q & gprop;
                        k_q      <= k_q + KW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign gg        = gg_q;
    assign pg        = pg_q;

endmodule

// File: tb/tb_seq_group_adder.sv
// Scoreboard bench for seq_group_adder: three instances (GROUP_BITS 8, 36, 4) share operands;
// expected results are queued at accept and compared when each instance hands off its result.
module tb_seq_group_adder;

    typedef struct packed {
        logic [35:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        gg;
        logic        pg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0;
    logic        op_sub = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [35:0] a = '0, b = '0;
    logic [2:0]  ir, ov, co, of, zr, ggw, pgw;
    logic [35:0] sm [3];

    res_t sbq [3][$];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    seq_group_adder #(.WIDTH(36), .GROUP_BITS(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op_sub(op_sub),
        .cin(cin), .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]),
        .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .gg(ggw[0]), .pg(pgw[0])
    );
    seq_group_adder #(.WIDTH(36), .GROUP_BITS(36)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op_sub(op_sub),
        .cin(cin), .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]),
        .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .gg(ggw[1]), .pg(pgw[1])
    );
    seq_group_adder #(.WIDTH(36), .GROUP_BITS(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op_sub(op_sub),
        .cin(cin), .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]),
        .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .gg(ggw[2]), .pg(pgw[2])
    );

    function automatic res_t model(input logic [35:0] fa, input logic [35:0] fb,
                                   input logic sub, input logic ci);
        logic [35:0] bp;
        logic [36:0] raw, full;
        res_t        r;
        bp     = sub ? ~fb : fb;
        raw    = {1'b0, fa} + {1'b0, bp};
        full   = raw + 37'(sub | ci);
        r.sum  = full[35:0];
        r.cout = full[36];
        r.ovf  = (fa[35] == bp[35]) && (full[35] != fa[35]);
        r.zero = (full[35:0] == 36'd0);
        r.gg   = raw[36];
        r.pg   = &(fa | bp);
        return r;
    endfunction

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && out_ready) begin
                    res_t got, exp;
                    got  = {sm[i], co[i], of[i], zr[i], ggw[i], pgw[i]};
                    nvec = nvec + 1;
                    if (sbq[i].size() == 0) begin
                        nerr = nerr + 1;
                        $display("FAIL unexpected_result u%0d: got %h, required none", i, got);
                    end else begin
                        exp = sbq[i].pop_front();
                        if (got !== exp) begin
                            nerr = nerr + 1;
                            $display("FAIL result u%0d: got %h, required %h", i, got, exp);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] mask, input logic [35:0] va, input logic [35:0] vb,
                         input logic vs, input logic vc);
        a = va; b = vb; op_sub = vs; cin = vc; iv = mask;
        step();
        iv = '0;
        for (int i = 0; i < 3; i++) if (mask[i]) sbq[i].push_back(model(va, vb, vs, vc));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        nvec = nvec + 3;
        if (ir !== 3'b111) begin
            nerr = nerr + 1;
            $display("FAIL reset_in_ready: got %b, required 111", ir);
        end
        if (ov !== 3'b000) begin
            nerr = nerr + 1;
            $display("FAIL reset_out_valid: got %b, required 000", ov);
        end
        if ({sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]} !== '0) begin
            nerr = nerr + 1;
            $display("FAIL reset_outputs: got %h, required 0",
                     {sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [35:0] va [3];
        logic [35:0] vb [3];
        logic        vs [3];
        int          cyc;
        va[0] = 36'o000000000001; vb[0] = 36'o777777777777; vs[0] = 1'b0;
        va[1] = 36'd5;            vb[1] = 36'd7;            vs[1] = 1'b1;
        va[2] = 36'o377777777777; vb[2] = 36'd1;            vs[2] = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            drive(3'b001, va[t], vb[t], vs[t], 1'b0);
            cyc = 0;
            while (!ov[0] && cyc < 20) begin
                step();
                cyc++;
            end
            nvec = nvec + 1;
            if (cyc != 6) begin
                nerr = nerr + 1;
                $display("FAIL latency_gb8 vec%0d: got %0d, required 6", t, cyc);
            end
            step();
            nvec = nvec + 1;
            if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
                nerr = nerr + 1;
                $display("FAIL return_idle vec%0d: got ir=%b ov=%b, required ir=1 ov=0",
                         t, ir[0], ov[0]);
            end
        end
    endtask

    task automatic test_hold();
        res_t exp;
        int   cyc;
        out_ready = 1'b0;
        exp = model(36'o123456701234, 36'o765432107654, 1'b0, 1'b1);
        drive(3'b001, 36'o123456701234, 36'o765432107654, 1'b0, 1'b1);
        cyc = 0;
        while (!ov[0] && cyc < 20) begin
            step();
            cyc++;
        end
        a = 36'o111111111111; b = 36'o222222222222; iv = 3'b001;
        for (int i = 0; i < 10; i++) begin
            step();
            nvec = nvec + 1;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 ||
                {sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]} !== exp) begin
                nerr = nerr + 1;
                $display("FAIL hold cyc%0d: got ov=%b ir=%b res=%h, required ov=1 ir=0 res=%h",
                         i, ov[0], ir[0], {sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]}, exp);
            end
        end
        iv = '0;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            nvec = nvec + 1;
            if (ov[0] !== 1'b0) begin
                nerr = nerr + 1;
                $display("FAIL hold_no_reaccept cyc%0d: got ov=%b, required 0", i, ov[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        drive(3'b001, 36'o000000777777, 36'o000000000001, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        if (sbq[0].size() != 0) void'(sbq[0].pop_front());
        nvec = nvec + 1;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            nerr = nerr + 1;
            $display("FAIL mid_reset: got ir=%b ov=%b, required ir=1 ov=0", ir[0], ov[0]);
        end
        step();
        rst_n = 1'b1;
        step();
        nvec = nvec + 1;
        if (ir[0] !== 1'b1) begin
            nerr = nerr + 1;
            $display("FAIL mid_reset_ready: got %b, required 1", ir[0]);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            nvec = nvec + 1;
            if (ov[0] !== 1'b0 || {sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]} !== '0) begin
                nerr = nerr + 1;
                $display("FAIL mid_reset_abort cyc%0d: got ov=%b res=%h, required ov=0 res=0",
                         i, ov[0], {sm[0], co[0], of[0], zr[0], ggw[0], pgw[0]});
            end
        end
    endtask

    task automatic test_group_latency();
        int lat1, lat2;
        out_ready = 1'b1;
        lat1 = -1;
        lat2 = -1;
        drive(3'b110, 36'o070707070707, 36'o707070707071, 1'b0, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ov[1] && lat1 < 0) lat1 = c;
            if (ov[2] && lat2 < 0) lat2 = c;
        end
        nvec = nvec + 2;
        if (lat1 != 2) begin
            nerr = nerr + 1;
            $display("FAIL latency_gb36: got %0d, required 2", lat1);
        end
        if (lat2 != 10) begin
            nerr = nerr + 1;
            $display("FAIL latency_gb4: got %0d, required 10", lat2);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] ra, rb;
        int          cyc;
        for (int n = 0; n < 60; n++) begin
            if (n == 0)      begin ra = '1; rb = '1; end
            else if (n == 1) begin ra = '0; rb = '0; end
            else if (n == 2) begin ra = 36'o400000000000; rb = 36'o400000000000; end
            else begin
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
            end
            out_ready = 1'b1;
            drive(3'b111, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc = 0;
            while (ir !== 3'b111 && cyc < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                cyc++;
            end
            if (cyc >= 60) begin
                nvec = nvec + 1;
                nerr = nerr + 1;
                $display("FAIL sweep_timeout n%0d: got ir=%b, required 111", n, ir);
            end
        end
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_group_latency();
        repeat (3) step();
        test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            nvec = nvec + 1;
            if (sbq[i].size() != 0) begin
                nerr = nerr + 1;
                $display("FAIL leftover u%0d: got %0d pending, required 0", i, sbq[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
